// File: rtl/telemetry_rs232_tx.sv
// rtl/telemetry_rs232_tx.sv - UART 8N1 telemetry packet transmitter (attitude and height)
module telemetry_rs232_tx #(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          BIT_CYCLES = CLK_FREQ / BAUD,
  parameter logic [7:0]  START_BYTE = 8'h0A,
  parameter logic [7:0]  STOP_BYTE  = 8'h08
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] cur_height,
  input  logic [15:0] cur_pitch,
  input  logic [15:0] cur_roll,
  input  logic [15:0] cur_yaw,
  output logic        busy,
  output logic        done,
  output logic        TxD
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [3:0] LAST_BYTE = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [3:0]       byte_idx;
  logic [7:0]       shreg;
  logic [7:0]       chk;
  logic [15:0]      snap_height;
  logic [15:0]      snap_pitch;
  logic [15:0]      snap_roll;
  logic [15:0]      snap_yaw;

  logic [3:0]       next_idx;
  logic [7:0]       next_byte;
  logic             bit_end;

  assign next_idx = byte_idx + 4'd1;
  assign bit_end  = (baud_cnt == BAUD_LAST);

  // Select the byte that follows the current one; the checksum slot reads the
  // accumulator, which already holds the XOR of all eight payload bytes by then.
  always_comb begin
    next_byte = STOP_BYTE;
    case (next_idx)
      4'd1:    next_byte = snap_height[15:8];
      4'd2:    next_byte = snap_height[7:0];
      4'd3:    next_byte = snap_pitch[15:8];
      4'd4:    next_byte = snap_pitch[7:0];
      4'd5:    next_byte = snap_roll[15:8];
      4'd6:    next_byte = snap_roll[7:0];
      4'd7:    next_byte = snap_yaw[15:8];
      4'd8:    next_byte = snap_yaw[7:0];
      4'd9:    next_byte = chk;
      default: next_byte = STOP_BYTE;
    endcase
  end

  // Packet FSM: snapshot on accept, then start/data/stop per byte with no gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      byte_idx    <= 4'd0;
      shreg       <= 8'h00;
      chk         <= 8'h00;
      snap_height <= 16'h0000;
      snap_pitch  <= 16'h0000;
      snap_roll   <= 16'h0000;
      snap_yaw    <= 16'h0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      TxD         <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            snap_height <= cur_height;
            snap_pitch  <= cur_pitch;
            snap_roll   <= cur_roll;
            snap_yaw    <= cur_yaw;
            chk         <= 8'h00;
            shreg       <= START_BYTE;
            byte_idx    <= 4'd0;
            bit_idx     <= 3'd0;
            baud_cnt    <= '0;
            TxD         <= 1'b0;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            TxD      <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              TxD   <= 1'b1;
              state <= STOP;
            end else begin
              TxD     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= next_idx;
              shreg    <= next_byte;
              if (next_idx <= 4'd8) begin
                chk <= chk ^ next_byte;
              end
              TxD      <= 1'b0;
              state    <= START;
            end else begin
              byte_idx <= 4'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_rs232_tx.sv
// tb/tb_telemetry_rs232_tx.sv - directed bench for telemetry_rs232_tx
module tb_telemetry_rs232_tx;

  localparam int CLK_FREQ = 2000000;
  localparam int BAUD     = 115200;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
  localparam int PKT      = 110 * BIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [15:0] cur_height = 16'h0;
  logic [15:0] cur_pitch = 16'h0;
  logic [15:0] cur_roll = 16'h0;
  logic [15:0] cur_yaw = 16'h0;
  logic        busy;
  logic        done;
  logic        TxD;

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   edge_bad = 0;
  int   last_edge = 0;
  logic edge_valid = 1'b0;
  logic prev_txd = 1'b1;

  int b0;
  int d0;
  int waited;

  always #10 clk = ~clk;

  telemetry_rs232_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .send(send),
    .cur_height(cur_height),
    .cur_pitch(cur_pitch),
    .cur_roll(cur_roll),
    .cur_yaw(cur_yaw),
    .busy(busy),
    .done(done),
    .TxD(TxD)
  );

  // Line monitor: busy/done cycle totals and bit-period alignment of TxD edges
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_txd <= TxD;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (TxD !== prev_txd) begin
      if (busy === 1'b1 && edge_valid && ((cyc - last_edge) % BIT) != 0)
        edge_bad <= edge_bad + 1;
      last_edge  <= cyc;
      edge_valid <= (busy === 1'b1);
    end else if (busy !== 1'b1) begin
      edge_valid <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse send for one accepting edge and confirm the start bit begins next cycle
  task automatic pulse_send(input string tag);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check_eq(tag, 32'({busy, TxD}), 32'h2);
  endtask

  // Decode 11 UART frames, comparing {stop, data, start} per byte
  task automatic rx_packet(input string tag, input logic [87:0] exp_pkt);
    logic [9:0] frame;
    logic [7:0] exp_byte;
    int         w;
    for (int i = 0; i < 11; i++) begin
      exp_byte = exp_pkt[87 - 8 * i -: 8];
      w = 0;
      while (TxD !== 1'b0 && w < 3 * BIT) begin
        @(negedge clk);
        w++;
      end
      if (TxD !== 1'b0) begin
        check_eq($sformatf("%s_b%0d_start_timeout", tag, i), 32'(TxD), 32'h0);
        return;
      end
      repeat (HALF) @(negedge clk);
      frame[0] = TxD;
      for (int b = 1; b <= 8; b++) begin
        repeat (BIT) @(negedge clk);
        frame[b] = TxD;
      end
      repeat (BIT) @(negedge clk);
      frame[9] = TxD;
      check_eq($sformatf("%s_b%0d", tag, i), 32'(frame), 32'({1'b1, exp_byte, 1'b0}));
    end
  endtask

  initial begin
    // reset held with send asserted: line stays idle
    rst_n = 1'b0;
    send  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("reset_idle", 32'({TxD, busy, done}), 32'h4);
    end
    send  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset", 32'({TxD, busy, done}), 32'h4);

    // single packet with signed boundary values
    cur_height = 16'h0123; cur_pitch = 16'hFFFE; cur_roll = 16'h7FFF; cur_yaw = 16'h8000;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_send("pkt1_first_fall");
    rx_packet("pkt1", 88'h0A_0123_FFFE_7FFF_8000_23_08);
    repeat (2 * BIT) @(negedge clk);
    check_eq("pkt1_busy_cycles", 32'(busy_cnt - b0), 32'(PKT));
    check_eq("pkt1_done_pulses", 32'(done_cnt - d0), 32'h1);

    // snapshot held; send and input changes during the frame are ignored
    cur_height = 16'h0; cur_pitch = 16'h0; cur_roll = 16'h0; cur_yaw = 16'h0;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_send("snap_first_fall");
    fork
      rx_packet("snap", 88'h0A_0000_0000_0000_0000_00_08);
      begin
        repeat (30 * BIT) @(negedge clk);
        cur_height = 16'h5555; cur_pitch = 16'h5555; cur_roll = 16'h5555; cur_yaw = 16'h5555;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    join
    repeat (2 * BIT) @(negedge clk);
    check_eq("snap_busy_cycles", 32'(busy_cnt - b0), 32'(PKT));
    check_eq("snap_done_pulses", 32'(done_cnt - d0), 32'h1);

    // back-to-back: send in the done cycle
    cur_height = 16'hABCD; cur_pitch = 16'h1234; cur_roll = 16'h0000; cur_yaw = 16'hFFFF;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_send("b2b1_first_fall");
    rx_packet("b2b1", 88'h0A_ABCD_1234_0000_FFFF_40_08);
    waited = 0;
    while (done !== 1'b1 && waited < 4 * BIT) begin
      @(negedge clk);
      waited++;
    end
    check_eq("b2b_done_seen", 32'({done, busy}), 32'h2);
    cur_height = 16'h0001; cur_pitch = 16'h0; cur_roll = 16'h0; cur_yaw = 16'h0;
    pulse_send("b2b2_start_next_cycle");
    rx_packet("b2b2", 88'h0A_0001_0000_0000_0000_01_08);
    repeat (2 * BIT) @(negedge clk);
    check_eq("b2b_busy_cycles", 32'(busy_cnt - b0), 32'(2 * PKT));
    check_eq("b2b_done_pulses", 32'(done_cnt - d0), 32'h2);

    // reset during byte 4 aborts the packet immediately
    cur_height = 16'h1111; cur_pitch = 16'h2222; cur_roll = 16'h3333; cur_yaw = 16'h4444;
    d0 = done_cnt;
    pulse_send("abort_first_fall");
    repeat (45 * BIT) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_line_idle", 32'({TxD, busy, done}), 32'h4);
    repeat (20 * BIT) @(negedge clk);
    check_eq("abort_quiet", 32'({TxD, busy}), 32'h2);
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'h0);

    // fresh packet after the abort
    cur_height = 16'h8001; cur_pitch = 16'h00FF; cur_roll = 16'hFF00; cur_yaw = 16'h0102;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_send("post_abort_first_fall");
    rx_packet("post_abort", 88'h0A_8001_00FF_FF00_0102_82_08);
    repeat (2 * BIT) @(negedge clk);
    check_eq("post_abort_busy_cycles", 32'(busy_cnt - b0), 32'(PKT));
    check_eq("post_abort_done_pulses", 32'(done_cnt - d0), 32'h1);

    check_eq("edge_alignment_errors", 32'(edge_bad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
